fp8_exec_sequencer: RTL and testbench

- Operation issue/sequencing stage of the 8-bit FPU, directly downstream of the exception module.
- Accepts an operation request (op, operand A, operand B) and consumes the exception module's `exc_flag`/`exc_code`, which are computed combinationally from the same request.
- Exceptional operations: returns a canonical special result without touching the arithmetic datapath.
- Non-exceptional operations: dispatches to the arithmetic unit over a req/ack handshake, with timeout protection, and presents one registered result per request.

---
 rtl/fp8_exec_sequencer.sv | 151 +++++++++++++++
 tb/tb_fp8_exec_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp8_exec_sequencer.sv
// FP8 issue/sequencing stage: canned results for exceptions, arith handshake otherwise.
// Optional FP8_STICKY_FLAGS_EN adds flags_clr / sticky_flags status accumulation.
`ifndef _ADDITION
`define _ADDITION 2'd0
`endif
`ifndef _SUBTRACTION
`define _SUBTRACTION 2'd1
`endif
`ifndef _MULTIPLICATION
`define _MULTIPLICATION 2'd2
`endif
`ifndef _DIVISION
`define _DIVISION 2'd3
`endif
`ifndef _NAN_0
`define _NAN_0 8'h7F
`endif

module fp8_exec_sequencer #(
    parameter int ARITH_TIMEOUT = 15,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_op,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       exc_flag,
    input  logic [2:0] exc_code,
    output logic       arith_req,
    output logic [1:0] arith_op,
    output logic [7:0] arith_a,
    output logic [7:0] arith_b,
    input  logic       arith_ack,
    input  logic [7:0] arith_result,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_result,
`ifdef FP8_STICKY_FLAGS_EN
    input  logic       flags_clr,
    output logic [7:0] sticky_flags,
`endif
    output logic [2:0] out_code
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(ARITH_TIMEOUT);
    localparam logic [2:0] CODE_TMO = 3'd7;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       exc_result;
    logic             accept;
    logic             out_fire;

    assign accept   = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Only divide-by-zero yields a signed infinity; every other flagged case is NaN.
    always_comb begin
        exc_result = `_NAN_0;
        if (exc_code == 3'd3)
            exc_result = {in_a[7] ^ in_b[7], 7'h78};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            in_ready   <= 1'b0;
            arith_req  <= 1'b0;
            arith_op   <= 2'd0;
            arith_a    <= 8'd0;
            arith_b    <= 8'd0;
            out_valid  <= 1'b0;
            out_result <= 8'd0;
            out_code   <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        in_ready <= 1'b0;
                        arith_op <= in_op;
                        arith_a  <= in_a;
                        arith_b  <= in_b;
                        cnt      <= '0;
                        if (exc_flag) begin
                            state      <= S_RESP;
                            out_valid  <= 1'b1;
                            out_result <= exc_result;
                            out_code   <= exc_code;
                        end else begin
                            state     <= S_ISSUE;
                            arith_req <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (arith_ack) begin
                        state      <= S_RESP;
                        arith_req  <= 1'b0;
                        out_valid  <= 1'b1;
                        out_result <= arith_result;
                        out_code   <= 3'd0;
                    end else if (cnt == TMO) begin
                        state      <= S_RESP;
                        arith_req  <= 1'b0;
                        out_valid  <= 1'b1;
                        out_result <= `_NAN_0;
                        out_code   <= CODE_TMO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (out_fire) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    arith_req <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FP8_STICKY_FLAGS_EN
    // The handshake's own bit is written last so it survives a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= 8'd0;
        end else begin
            if (flags_clr)
                sticky_flags <= 8'd0;
            if (out_fire)
                sticky_flags[out_code] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fp8_exec_sequencer.sv
// Directed bench for fp8_exec_sequencer with ARITH_TIMEOUT=4.
// Also checks sticky_flags when built with FP8_STICKY_FLAGS_EN.
`ifndef _ADDITION
`define _ADDITION 2'd0
`endif
`ifndef _SUBTRACTION
`define _SUBTRACTION 2'd1
`endif
`ifndef _MULTIPLICATION
`define _MULTIPLICATION 2'd2
`endif
`ifndef _DIVISION
`define _DIVISION 2'd3
`endif
`ifndef _NAN_0
`define _NAN_0 8'h7F
`endif

module tb_fp8_exec_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       exc_flag;
    logic [2:0] exc_code;
    logic       arith_req;
    logic [1:0] arith_op;
    logic [7:0] arith_a;
    logic [7:0] arith_b;
    logic       arith_ack;
    logic [7:0] arith_result;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [2:0] out_code;
`ifdef FP8_STICKY_FLAGS_EN
    logic       flags_clr;
    logic [7:0] sticky_flags;
`endif

    int total = 0;
    int bad = 0;

    fp8_exec_sequencer #(.ARITH_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_op(in_op),
        .in_a(in_a),
        .in_b(in_b),
        .exc_flag(exc_flag),
        .exc_code(exc_code),
        .arith_req(arith_req),
        .arith_op(arith_op),
        .arith_a(arith_a),
        .arith_b(arith_b),
        .arith_ack(arith_ack),
        .arith_result(arith_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
`ifdef FP8_STICKY_FLAGS_EN
        .flags_clr(flags_clr),
        .sticky_flags(sticky_flags),
`endif
        .out_code(out_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic flag, input logic [2:0] code);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        exc_flag = flag;
        exc_code = code;
        step();
        in_valid = 1'b0;
        exc_flag = 1'b0;
        exc_code = 3'd0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0;
        in_op = 2'd0;
        in_a = 8'd0;
        in_b = 8'd0;
        exc_flag = 1'b0;
        exc_code = 3'd0;
        arith_ack = 1'b0;
        arith_result = 8'd0;
        out_ready = 1'b0;
`ifdef FP8_STICKY_FLAGS_EN
        flags_clr = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_arith_req", arith_req, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_code", out_code, 0);
        #4 rst_n = 1'b1;
        step();
        chk("rel_in_ready", in_ready, 1);

        // NaN operand
        send(`_ADDITION, `_NAN_0, 8'h00, 1'b1, 3'd1);
        chk("nan_valid", out_valid, 1);
        chk("nan_req", arith_req, 0);
        chk("nan_result", out_result, `_NAN_0);
        chk("nan_code", out_code, 1);
        chk("nan_in_ready", in_ready, 0);
        drain();
        chk("nan_done_valid", out_valid, 0);
        chk("nan_done_ready", in_ready, 1);

        // -1.0 / 0 -> -Inf
        send(`_DIVISION, 8'hB8, 8'h00, 1'b1, 3'd3);
        chk("dz_result", out_result, 8'hF8);
        chk("dz_code", out_code, 3);
        chk("dz_req", arith_req, 0);
        drain();

        // +1.0 / +0 -> +Inf
        send(`_DIVISION, 8'h38, 8'h00, 1'b1, 3'd3);
        chk("dzp_result", out_result, 8'h78);
        drain();

        // flag with code 0 still gives NaN, reserved code is passed through
        send(`_SUBTRACTION, 8'h38, 8'h40, 1'b1, 3'd0);
        chk("f0_result", out_result, `_NAN_0);
        chk("f0_code", out_code, 0);
        drain();
        send(`_ADDITION, 8'h38, 8'h40, 1'b1, 3'd6);
        chk("r6_result", out_result, `_NAN_0);
        chk("r6_code", out_code, 6);
        drain();

        // normal path; ack lands on the same edge the timeout would fire
        send(`_MULTIPLICATION, 8'h38, 8'h40, 1'b0, 3'd0);
        chk("mul_req", arith_req, 1);
        chk("mul_op", arith_op, `_MULTIPLICATION);
        chk("mul_a", arith_a, 8'h38);
        chk("mul_b", arith_b, 8'h40);
        chk("mul_valid0", out_valid, 0);
        arith_result = 8'h55;
        for (int i = 0; i < 4; i++) step();
        chk("mul_wait_valid", out_valid, 0);
        chk("mul_wait_req", arith_req, 1);
        arith_ack = 1'b1;
        arith_result = 8'h40;
        step();
        arith_ack = 1'b0;
        chk("mul_valid", out_valid, 1);
        chk("mul_result", out_result, 8'h40);
        chk("mul_code", out_code, 0);
        chk("mul_req_drop", arith_req, 0);

        // backpressure while a new request waits
        in_valid = 1'b1;
        in_op = `_ADDITION;
        in_a = 8'h11;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_result", out_result, 8'h40);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        drain();
        chk("bp_done_valid", out_valid, 0);
        chk("bp_done_ready", in_ready, 1);

        // timeout with a late ack
        send(`_ADDITION, 8'h38, 8'h38, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_req_hold", arith_req, 1);
        end
        step();
        chk("to_req_drop", arith_req, 0);
        chk("to_valid", out_valid, 1);
        chk("to_result", out_result, `_NAN_0);
        chk("to_code", out_code, 7);
        arith_ack = 1'b1;
        arith_result = 8'h22;
        step();
        arith_ack = 1'b0;
        chk("late_result", out_result, `_NAN_0);
        chk("late_code", out_code, 7);
        drain();

`ifdef FP8_STICKY_FLAGS_EN
        chk("sticky", sticky_flags, 8'hCB);
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        chk("sticky_clr", sticky_flags, 0);
`endif

        // async reset in the middle of ISSUE
        send(`_ADDITION, 8'h38, 8'h30, 1'b0, 3'd0);
        step();
        chk("mid_req", arith_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", arith_req, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 0);
        #3 rst_n = 1'b1;
        step();
        chk("mid_rel_ready", in_ready, 1);
        chk("mid_rel_valid", out_valid, 0);

        send(`_SUBTRACTION, 8'h40, 8'h38, 1'b0, 3'd0);
        arith_ack = 1'b1;
        arith_result = 8'h38;
        step();
        arith_ack = 1'b0;
        chk("post_result", out_result, 8'h38);
        chk("post_valid", out_valid, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
